// File: rtl/voter_ledger_ctrl.sv
// Ballot gate: one vote per ledger address, repeat attempts rejected, registered ballot tally.
// Optional GRANT abandon timer is enabled by defining LEDGER_TIMEOUT_EN.
module voter_ledger_ctrl #(
    parameter int WORD_SIZE      = 5,
    parameter int ADDRESS_SIZE   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic                    voter_id_status,
    input  logic [WORD_SIZE-1:0]    valid_voter,
    input  logic [ADDRESS_SIZE-1:0] valid_voter_address,
    input  logic                    clear_req,
    input  logic                    vote_done,
    output logic                    vote_enable,
    output logic                    duplicate_voter,
    output logic                    vote_timeout,
    output logic                    busy,
    output logic [WORD_SIZE-1:0]    current_voter,
    output logic [ADDRESS_SIZE:0]   voter_count,
    output logic                    ledger_full
);
    localparam int                DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] FULL = (ADDRESS_SIZE + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOOKUP, GRANT, REJECT, RELEASE} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH-1:0]        ledger_q, ledger_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    voter_q, voter_d;
    logic                    enable_q, dup_q, busy_q;
    logic                    req;
    logic                    expire;

    // status gates write so an undriven strobe cannot form a request
    assign req = write & voter_id_status;

`ifdef LEDGER_TIMEOUT_EN
    localparam int              TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_q;
    logic          timeout_q;

    assign expire = (state_q == GRANT) && (tcnt_q == TLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= (state_q == GRANT) ? tcnt_q + 1'b1 : '0;
            timeout_q <= expire && !vote_done;
        end
    end

    assign vote_timeout = timeout_q;
`else
    assign expire       = 1'b0;
    assign vote_timeout = 1'b0;
`endif

    // TIMEOUT_CYCLES below 2 leaves no room between GRANT entry and expiry
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_below_min
    end

    always_comb begin
        state_d  = state_q;
        ledger_d = ledger_q;
        count_d  = count_q;
        addr_d   = addr_q;
        voter_d  = voter_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    ledger_d = '0;
                    count_d  = '0;
                end else if (req) begin
                    addr_d  = valid_voter_address;
                    voter_d = valid_voter;
                    state_d = LOOKUP;
                end
            end
            LOOKUP:  state_d = ledger_q[addr_q] ? REJECT : GRANT;
            GRANT: begin
                // a vote arriving on the expiry cycle still counts
                if (vote_done) begin
                    ledger_d[addr_q] = 1'b1;
                    if (count_q != FULL) count_d = count_q + 1'b1;
                    state_d = RELEASE;
                end else if (expire) begin
                    state_d = RELEASE;
                end
            end
            REJECT:  state_d = RELEASE;
            RELEASE: begin
                if (clear_req) begin
                    ledger_d = '0;
                    count_d  = '0;
                end
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ledger_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            voter_q  <= '0;
            enable_q <= 1'b0;
            dup_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ledger_q <= ledger_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            voter_q  <= voter_d;
            enable_q <= (state_d == GRANT);
            dup_q    <= (state_d == REJECT);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign vote_enable     = enable_q;
    assign duplicate_voter = dup_q;
    assign busy            = busy_q;
    assign current_voter   = voter_q;
    assign voter_count     = count_q;
    assign ledger_full     = (count_q == FULL);
endmodule

// File: tb/tb_voter_ledger_ctrl.sv
// Directed bench for voter_ledger_ctrl; timeout scenarios run when LEDGER_TIMEOUT_EN is defined.
module tb_voter_ledger_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic       voter_id_status;
    logic [4:0] valid_voter;
    logic [3:0] valid_voter_address;
    logic       clear_req;
    logic       vote_done;
    logic       vote_enable;
    logic       duplicate_voter;
    logic       vote_timeout;
    logic       busy;
    logic [4:0] current_voter;
    logic [4:0] voter_count;
    logic       ledger_full;

    int checks = 0;
    int errors = 0;
    logic last_ve, last_dup;

    voter_ledger_ctrl #(.WORD_SIZE(5), .ADDRESS_SIZE(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .write(write), .voter_id_status(voter_id_status),
        .valid_voter(valid_voter), .valid_voter_address(valid_voter_address),
        .clear_req(clear_req), .vote_done(vote_done), .vote_enable(vote_enable),
        .duplicate_voter(duplicate_voter), .vote_timeout(vote_timeout), .busy(busy),
        .current_voter(current_voter), .voter_count(voter_count), .ledger_full(ledger_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [3:0] a, input logic [4:0] id);
        write = 1'b1; voter_id_status = 1'b1;
        valid_voter_address = a; valid_voter = id;
    endtask

    task automatic drop_req();
        write = 1'b0; voter_id_status = 1'b0;
    endtask

    // Full session: request, record grant/reject seen at N+2, optionally vote, release to IDLE.
    task automatic session(input logic [3:0] a, input logic [4:0] id, input bit do_vote);
        drive_req(a, id);
        step(); step();
        last_ve = vote_enable; last_dup = duplicate_voter;
        if (do_vote && vote_enable) begin
            vote_done = 1'b1; step(); vote_done = 1'b0;
        end else begin
            step();
        end
        drop_req(); step();
    endtask

    task automatic test_reset();
        reset = 1'b1; write = 1'bx; voter_id_status = 1'b0;
        valid_voter = '0; valid_voter_address = 'x; clear_req = 1'b0; vote_done = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (vote_enable !== 1'b0 || duplicate_voter !== 1'b0 || vote_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ve=%b dup=%b to=%b want 000", vote_enable, duplicate_voter, vote_timeout); end
        checks++; if (voter_count !== 5'd0 || ledger_full !== 1'b0) begin
            errors++; $display("FAIL reset_count: got %0d full=%b want 0/0", voter_count, ledger_full); end
        checks++; if (current_voter !== 5'd0) begin errors++; $display("FAIL reset_voter: got %0d want 0", current_voter); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_x_write: busy=%b want 0", busy); end
    endtask

    task automatic test_grant();
        drive_req(4'd3, 5'b00011);
        step();
        checks++; if (busy !== 1'b1 || vote_enable !== 1'b0) begin
            errors++; $display("FAIL grant_lookup: busy=%b ve=%b want 1/0", busy, vote_enable); end
        valid_voter = 5'd30; valid_voter_address = 4'd9;
        step();
        checks++; if (vote_enable !== 1'b1) begin errors++; $display("FAIL grant_enable: got %b want 1", vote_enable); end
        checks++; if (current_voter !== 5'b00011) begin errors++; $display("FAIL grant_voter: got %0d want 3", current_voter); end
        step();
        vote_done = 1'b1; step(); vote_done = 1'b0;
        checks++; if (voter_count !== 5'd1 || vote_enable !== 1'b0) begin
            errors++; $display("FAIL grant_count: count=%0d ve=%b want 1/0", voter_count, vote_enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_release_busy: got %b want 1", busy); end
        drop_req(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL grant_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_duplicate();
        int ve_seen = 0;
        int dup_cycles = 0;
        vote_done = 1'b1;
        step();
        vote_done = 1'b0;
        drive_req(4'd3, 5'd7);
        for (int i = 0; i < 4; i++) begin
            step();
            if (vote_enable) ve_seen++;
            if (duplicate_voter) dup_cycles++;
            if (i == 1) begin
                checks++; if (duplicate_voter !== 1'b1) begin errors++; $display("FAIL dup_n2: got %b want 1", duplicate_voter); end
            end
        end
        checks++; if (dup_cycles != 1 || ve_seen != 0) begin
            errors++; $display("FAIL dup_pulse: dup_cycles=%0d ve_cycles=%0d want 1/0", dup_cycles, ve_seen); end
        checks++; if (voter_count !== 5'd1) begin errors++; $display("FAIL dup_count: got %0d want 1", voter_count); end
        drop_req(); step();
    endtask

    task automatic test_held_request();
        int stray = 0;
        drive_req(4'd5, 5'd9);
        step(); step();
        vote_done = 1'b1; step(); vote_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b1 || vote_enable !== 1'b0 || duplicate_voter !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL held_release: bad cycles=%0d want 0", stray); end
        checks++; if (voter_count !== 5'd2) begin errors++; $display("FAIL held_count: got %0d want 2", voter_count); end
        drop_req(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_clear();
        drive_req(4'd6, 5'd10);
        step(); step();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        checks++; if (vote_enable !== 1'b1 || voter_count !== 5'd2) begin
            errors++; $display("FAIL clear_in_grant: ve=%b count=%0d want 1/2", vote_enable, voter_count); end
        vote_done = 1'b1; step(); vote_done = 1'b0;
        checks++; if (voter_count !== 5'd3) begin errors++; $display("FAIL clear_vote: got %0d want 3", voter_count); end
        clear_req = 1'b1; step(); clear_req = 1'b0;
        checks++; if (voter_count !== 5'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL clear_in_release: count=%0d busy=%b want 0/1", voter_count, busy); end
        drop_req(); step();
        session(4'd7, 5'd1, 1'b1);
        checks++; if (voter_count !== 5'd1) begin errors++; $display("FAIL clear_revote: got %0d want 1", voter_count); end
        clear_req = 1'b1; drive_req(4'd8, 5'd2); step(); clear_req = 1'b0; drop_req();
        checks++; if (voter_count !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_idle: count=%0d busy=%b want 0/0", voter_count, busy); end
        session(4'd3, 5'b00011, 1'b1);
        checks++; if (last_ve !== 1'b1 || voter_count !== 5'd1) begin
            errors++; $display("FAIL clear_addr3: ve=%b count=%0d want 1/1", last_ve, voter_count); end
    endtask

    task automatic test_full();
        for (int a = 0; a < 16; a++) begin
            if (a != 3) session(4'(a), 5'(a + 1), 1'b1);
            if (a == 14) begin
                checks++; if (voter_count !== 5'd15 || ledger_full !== 1'b0) begin
                    errors++; $display("FAIL full_15: count=%0d full=%b want 15/0", voter_count, ledger_full); end
            end
        end
        checks++; if (voter_count !== 5'd16 || ledger_full !== 1'b1) begin
            errors++; $display("FAIL full_16: count=%0d full=%b want 16/1", voter_count, ledger_full); end
        session(4'd9, 5'd20, 1'b1);
        checks++; if (last_dup !== 1'b1 || last_ve !== 1'b0 || voter_count !== 5'd16) begin
            errors++; $display("FAIL full_extra: dup=%b ve=%b count=%0d want 1/0/16", last_dup, last_ve, voter_count); end
    endtask

    task automatic test_reset_in_grant();
        reset = 1'b1; step(); reset = 1'b0;
        session(4'd2, 5'd4, 1'b0);
        checks++; if (last_dup !== 1'b0 || last_ve !== 1'b1) begin
            errors++; $display("FAIL rig_ledger_wiped: dup=%b ve=%b want 0/1", last_dup, last_ve); end
        drive_req(4'd2, 5'd4);
        step(); step();
        reset = 1'b1; drop_req(); step(); reset = 1'b0;
        checks++; if (busy !== 1'b0 || vote_enable !== 1'b0 || voter_count !== 5'd0) begin
            errors++; $display("FAIL rig_abort: busy=%b ve=%b count=%0d want 0/0/0", busy, vote_enable, voter_count); end
        session(4'd2, 5'd4, 1'b1);
        checks++; if (last_ve !== 1'b1 || voter_count !== 5'd1) begin
            errors++; $display("FAIL rig_regrant: ve=%b count=%0d want 1/1", last_ve, voter_count); end
    endtask

`ifdef LEDGER_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        drive_req(4'd4, 5'd12);
        step(); step();
        for (int i = 0; i < 7; i++) begin
            step();
            if (vote_timeout !== 1'b0 || vote_enable !== 1'b1) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early: bad cycles=%0d want 0", early); end
        step();
        checks++; if (vote_timeout !== 1'b1 || vote_enable !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_pulse: to=%b ve=%b busy=%b want 1/0/1", vote_timeout, vote_enable, busy); end
        step();
        checks++; if (vote_timeout !== 1'b0 || voter_count !== 5'd1) begin
            errors++; $display("FAIL to_after: to=%b count=%0d want 0/1", vote_timeout, voter_count); end
        drop_req(); step();
        drive_req(4'd4, 5'd12);
        step(); step();
        checks++; if (vote_enable !== 1'b1) begin errors++; $display("FAIL to_ledger_unchanged: ve=%b want 1", vote_enable); end
        for (int i = 0; i < 7; i++) step();
        vote_done = 1'b1; step(); vote_done = 1'b0;
        checks++; if (vote_timeout !== 1'b0 || voter_count !== 5'd2) begin
            errors++; $display("FAIL to_expiry_vote: to=%b count=%0d want 0/2", vote_timeout, voter_count); end
        step();
        checks++; if (vote_timeout !== 1'b0) begin errors++; $display("FAIL to_expiry_late: to=%b want 0", vote_timeout); end
        drop_req(); step();
    endtask
`endif

    initial begin
        test_reset();
        test_grant();
        test_duplicate();
        test_held_request();
        test_clear();
        test_full();
        test_reset_in_grant();
`ifdef LEDGER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
